// File: rtl/sb2p_mem_pkg.sv
// Shared types and sizing helpers for the MEM stage and the MEM/WB register.
package sb2p_mem_pkg;

  localparam int DW_DEF      = 32;
  localparam int RW_DEF      = 5;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // A timeout of 0 disables the abort, but the counter still needs one bit.
  function automatic int cnt_width(input int timeout_cyc);
    return (timeout_cyc < 1) ? 1 : $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble load clears every field so that nothing
// stale can reach the write-back mux.
module mem_wb_reg
  import sb2p_mem_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bubble,
  input  logic          d_regwrite,
  input  logic          d_memtoreg,
  input  logic [DW-1:0] d_readdata,
  input  logic [DW-1:0] d_aluresult,
  input  logic [RW-1:0] d_rd,
  output logic          regwrite_q,
  output logic          memtoreg_q,
  output logic [DW-1:0] readdata_q,
  output logic [DW-1:0] aluresult_q,
  output logic [RW-1:0] rd_q
);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      readdata_q  <= '0;
      aluresult_q <= '0;
      rd_q        <= '0;
    end else begin
      regwrite_q  <= d_regwrite;
      memtoreg_q  <= d_memtoreg;
      readdata_q  <= d_readdata;
      aluresult_q <= d_aluresult;
      rd_q        <= d_rd;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: runs the data-memory req/ack access, stalls the front end while it
// is pending and feeds the MEM/WB register.
module mem_wb_stage
  import sb2p_mem_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int RW          = RW_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          regwrite_in,
  input  logic          memtoreg_in,
  input  logic          memread_in,
  input  logic          memwrite_in,
  input  logic [DW-1:0] aluresult_in,
  input  logic [DW-1:0] storedata_in,
  input  logic [RW-1:0] rd_in,
  output logic          stall,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          regwrite_out,
  output logic          memtoreg_out,
  output logic [DW-1:0] readdata_out,
  output logic [DW-1:0] aluresult_out,
  output logic [RW-1:0] rd_out,
  output logic          err_out
);

  localparam int CW = cnt_width(TIMEOUT_CYC);

  mem_state_t state, state_nxt;
  logic [CW-1:0] cnt;

  logic          cap_regwrite;
  logic          cap_memtoreg;
  logic          cap_load;
  logic [RW-1:0] cap_rd;
  logic [DW-1:0] cap_alu;

  logic          access;
  logic          misaligned;
  logic          timeout;
  logic          start;
  logic          finish;
  logic          err_nxt;

  logic          wb_bubble;
  logic          wb_regwrite;
  logic          wb_memtoreg;
  logic [DW-1:0] wb_readdata;
  logic [DW-1:0] wb_aluresult;
  logic [RW-1:0] wb_rd;

  assign access     = memread_in | memwrite_in;
  assign misaligned = (aluresult_in[1:0] != 2'b00);
  assign timeout    = (TIMEOUT_CYC != 0) && (cnt == CW'(TIMEOUT_CYC));

  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    start        = 1'b0;
    finish       = 1'b0;
    err_nxt      = 1'b0;
    wb_bubble    = 1'b1;
    wb_regwrite  = 1'b0;
    wb_memtoreg  = 1'b0;
    wb_readdata  = '0;
    wb_aluresult = '0;
    wb_rd        = '0;

    case (state)
      IDLE: begin
        if (!access) begin
          wb_bubble    = 1'b0;
          wb_regwrite  = regwrite_in;
          wb_memtoreg  = memtoreg_in;
          wb_aluresult = aluresult_in;
          wb_rd        = rd_in;
        end else if (misaligned) begin
          // Dropped access still shows its address and rd for debug, but never writes back.
          wb_bubble    = 1'b0;
          wb_aluresult = aluresult_in;
          wb_rd        = rd_in;
          err_nxt      = 1'b1;
        end else begin
          stall     = 1'b1;
          start     = 1'b1;
          err_nxt   = memread_in & memwrite_in;
          state_nxt = BUSY;
        end
      end

      BUSY: begin
        if (dmem_ack || timeout) begin
          finish       = 1'b1;
          wb_bubble    = 1'b0;
          wb_regwrite  = dmem_ack ? cap_regwrite : 1'b0;
          wb_memtoreg  = cap_memtoreg;
          wb_readdata  = (dmem_ack && cap_load) ? dmem_rdata : '0;
          wb_aluresult = cap_alu;
          wb_rd        = cap_rd;
          err_nxt      = !dmem_ack;
          state_nxt    = IDLE;
        end else begin
          stall = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      stall = 1'b0;
    end
  end

  // Bus signals are held from capture until completion so the memory sees a stable request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      err_out      <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      cap_regwrite <= 1'b0;
      cap_memtoreg <= 1'b0;
      cap_load     <= 1'b0;
      cap_rd       <= '0;
      cap_alu      <= '0;
    end else begin
      state   <= state_nxt;
      err_out <= err_nxt;
      if (start) begin
        cap_regwrite <= regwrite_in;
        cap_memtoreg <= memtoreg_in;
        cap_load     <= memread_in & ~memwrite_in;
        cap_rd       <= rd_in;
        cap_alu      <= aluresult_in;
        dmem_req     <= 1'b1;
        dmem_we      <= memwrite_in;
        dmem_addr    <= {aluresult_in[DW-1:2], 2'b00};
        dmem_wdata   <= storedata_in;
        cnt          <= '0;
      end else if (finish) begin
        dmem_req <= 1'b0;
        cnt      <= '0;
      end else if ((state == BUSY) && (TIMEOUT_CYC != 0)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  mem_wb_reg #(
    .DW(DW),
    .RW(RW)
  ) u_mem_wb_reg (
    .clk        (clk),
    .rst        (rst),
    .bubble     (wb_bubble),
    .d_regwrite (wb_regwrite),
    .d_memtoreg (wb_memtoreg),
    .d_readdata (wb_readdata),
    .d_aluresult(wb_aluresult),
    .d_rd       (wb_rd),
    .regwrite_q (regwrite_out),
    .memtoreg_q (memtoreg_out),
    .readdata_q (readdata_out),
    .aluresult_q(aluresult_out),
    .rd_q       (rd_out)
  );

endmodule
